// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared types and lane helpers for the AXI4-Lite LSU.
// Helpers work on a 64-bit lane view; callers truncate to DATA_W.
package ysyx_25010008_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StRaddr,
        StRdata,
        StWreq,
        StBresp,
        StResp
    } lsu_state_e;

    // EXOKAY is meaningless on AXI4-Lite, so anything but OKAY is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == EXOKAY) || (resp == SLVERR) || (resp == DECERR);
    endfunction

    function automatic logic [2:0] size_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

    function automatic logic [63:0] lane_shift(input logic [63:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [7:0] lane_strb(input logic [2:0] off, input logic [1:0] size);
        logic [8:0] m;
        m = (9'd1 << (4'd1 << size)) - 9'd1;
        return m[7:0] << off;
    endfunction

    function automatic logic [63:0] lane_extract(input logic [63:0] data, input logic [2:0] off,
                                                 input logic [1:0] size, input logic sext);
        logic [63:0] s;
        s = data >> {off, 3'b000};
        case (size)
            SZ_B:    return {{56{sext & s[7]}}, s[7:0]};
            SZ_H:    return {{48{sext & s[15]}}, s[15:0]};
            SZ_W:    return {{32{sext & s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_lfsr.sv
// Galois LFSR producing the random issue delay.
// Only built when YSYX_25010008_LSU_DELAY_EN is defined.
`ifdef YSYX_25010008_LSU_DELAY_EN
module ysyx_25010008_lsu_lfsr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= SEED;
        end else begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule
`endif

// File: rtl/ysyx_25010008_lsu_axi_master.sv
// Load/store unit: one CPU request at a time onto AXI4-Lite, with alignment checks.
// Define YSYX_25010008_LSU_DELAY_EN to insert a random LFSR delay before bus issue.
module ysyx_25010008_lsu_axi_master
    import ysyx_25010008_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DELAY_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    if ((DATA_W != 32 && DATA_W != 64) || DELAY_W < 2) begin : g_bad_param
        $error("lsu_axi_master: DATA_W must be 32 or 64 and DELAY_W >= 2");
    end

    lsu_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done_q;
    logic              w_done_q;

    logic              src_wen;
    logic [ADDR_W-1:0] src_addr;
    logic [1:0]        src_size;
    logic [DATA_W-1:0] src_wdata;
    logic [2:0]        off3;
    logic [ADDR_W-1:0] aligned;
    logic              bad_req;
    logic              aw_fin;
    logic              w_fin;
    logic              go_issue;

    // In IDLE decode straight from the request; afterwards from the latched copy.
    always_comb begin
        if (state == StIdle) begin
            src_wen   = req_wen;
            src_addr  = req_addr;
            src_size  = req_size;
            src_wdata = req_wdata;
        end else begin
            src_wen   = wen_q;
            src_addr  = addr_q;
            src_size  = size_q;
            src_wdata = wdata_q;
        end
    end

    assign off3      = 3'(src_addr[OFF_W-1:0]);
    assign aligned   = {src_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bad_req   = ((off3 & size_mask(src_size)) != 3'd0) || (src_size == SZ_D && DATA_W == 32);
    assign aw_fin    = aw_done_q | (awvalid & awready);
    assign w_fin     = w_done_q | (wvalid & wready);
    assign req_ready = (state == StIdle);

`ifdef YSYX_25010008_LSU_DELAY_EN
    logic [DELAY_W-1:0] lfsr_val;
    logic [DELAY_W-1:0] dly_cnt_q;

    ysyx_25010008_lsu_lfsr #(
        .WIDTH (DELAY_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_val)
    );

    assign go_issue = (state == StDelay) && (dly_cnt_q == '0);
`else
    assign go_issue = (state == StIdle) && req_valid && !bad_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            addr_q     <= '0;
            size_q     <= SZ_B;
            sext_q     <= 1'b0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
`ifdef YSYX_25010008_LSU_DELAY_EN
            dly_cnt_q  <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        sext_q    <= req_sext;
                        wen_q     <= req_wen;
                        wdata_q   <= req_wdata;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        resp_err  <= 1'b0;
                        if (bad_req) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
`ifdef YSYX_25010008_LSU_DELAY_EN
                        else begin
                            state     <= StDelay;
                            dly_cnt_q <= lfsr_val;
                        end
`endif
                    end
                end
`ifdef YSYX_25010008_LSU_DELAY_EN
                StDelay: begin
                    if (dly_cnt_q != '0) dly_cnt_q <= dly_cnt_q - DELAY_W'(1);
                end
`endif
                StRaddr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= StRdata;
                    end
                end
                StRdata: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= resp_is_err(rresp);
                        resp_rdata <= resp_is_err(rresp) ? '0 :
                            DATA_W'(lane_extract(64'(rdata), off3, size_q, sext_q));
                        state      <= StResp;
                    end
                end
                StWreq: begin
                    if (awvalid && awready) begin
                        awvalid   <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid   <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready <= 1'b1;
                        state  <= StBresp;
                    end
                end
                StBresp: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= resp_is_err(bresp);
                        resp_rdata <= '0;
                        state      <= StResp;
                    end
                end
                StResp:  state <= StIdle;
                default: state <= StIdle;
            endcase

            if (go_issue) begin
                if (src_wen) begin
                    awaddr  <= aligned;
                    wdata   <= DATA_W'(lane_shift(64'(src_wdata), off3));
                    wstrb   <= STRB_W'(lane_strb(off3, src_size));
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    state   <= StWreq;
                end else begin
                    araddr  <= aligned;
                    arvalid <= 1'b1;
                    state   <= StRaddr;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_lsu_axi_master.sv
// Self-checking bench for ysyx_25010008_lsu_axi_master (DATA_W=32, delay feature off).
module tb_ysyx_25010008_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_sext = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic [3:0]  wstrb;

    ysyx_25010008_lsu_axi_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DELAY_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_sext   (req_sext),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdat;
        logic [31:0] bus_rdata;
        logic [1:0]  resp;
        logic        bus;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   aw_hs = 0;
    int   w_hs = 0;
    logic prev_rv = 1'b0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
        end else begin
            if (resp_valid) begin
                chk("resp_one_cycle", prev_rv, 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t",
                             $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", resp_err, mon_e.err);
                end
            end
            prev_rv = resp_valid;
        end
    end

    always @(posedge clk) begin
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready) w_hs++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                             input logic sext, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_size  = size;
        req_sext  = sext;
        req_wdata = wd;
        chk("req_ready_idle", req_ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        drive_req(v.wen, v.addr, v.size, v.sext, v.wdat);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_not_ready", req_ready && !resp_valid, 0);
        if (!v.bus) begin
            chk("err_latency", resp_valid, 1);
            repeat (2) begin
                chk("no_bus", {arvalid, awvalid, wvalid}, 0);
                @(negedge clk);
            end
        end else if (!v.wen) begin
            n = 0;
            while (!arvalid && n < 20) begin @(negedge clk); n++; end
            chk("ar_issue_latency", n, 0);
            chk("araddr", araddr, v.exp_addr);
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            chk("ar_drop", arvalid, 0);
            chk("rready_up", rready, 1);
            rvalid = 1'b1;
            rdata  = v.bus_rdata;
            rresp  = v.resp;
            @(negedge clk);
            rvalid = 1'b0;
            rresp  = '0;
            chk("rready_drop", rready, 0);
        end else begin
            n = 0;
            while (!awvalid && n < 20) begin @(negedge clk); n++; end
            chk("aw_issue_latency", n, 0);
            chk("aw_w_together", {awvalid, wvalid}, 2'b11);
            chk("awaddr", awaddr, v.exp_addr);
            chk("wdata", wdata, v.exp_wdata);
            chk("wstrb", wstrb, v.exp_wstrb);
            awready = 1'b1;
            wready  = 1'b1;
            @(negedge clk);
            awready = 1'b0;
            wready  = 1'b0;
            chk("bready_up", bready, 1);
            bvalid = 1'b1;
            bresp  = v.resp;
            @(negedge clk);
            bvalid = 1'b0;
            bresp  = '0;
            chk("bready_drop", bready, 0);
        end
        drain();
    endtask

    vec_t vecs[12];
    int   n;

    initial begin
        // wen addr size sext wdata bus_rdata resp bus exp_addr exp_wdata exp_wstrb exp_rdata err
        vecs[0]  = '{0, 32'h8000_0003, 2'd0, 1, 32'h0, 32'h80FF_0000, 2'd0, 1,
                     32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FF80, 0};
        vecs[1]  = '{1, 32'h8000_0002, 2'd1, 0, 32'h0000_BEEF, 32'h0, 2'd0, 1,
                     32'h8000_0000, 32'hBEEF_0000, 4'b1100, 32'h0, 0};
        vecs[2]  = '{0, 32'h8000_0001, 2'd2, 0, 32'h0, 32'h0, 2'd0, 0,
                     32'h0, 32'h0, 4'h0, 32'h0, 1};
        vecs[3]  = '{0, 32'h8000_0000, 2'd3, 0, 32'h0, 32'h0, 2'd0, 0,
                     32'h0, 32'h0, 4'h0, 32'h0, 1};
        vecs[4]  = '{0, 32'h8000_0004, 2'd2, 0, 32'h0, 32'h1234_5678, 2'd2, 1,
                     32'h8000_0004, 32'h0, 4'h0, 32'h0, 1};
        vecs[5]  = '{1, 32'h8000_0008, 2'd2, 0, 32'hCAFE_F00D, 32'h0, 2'd3, 1,
                     32'h8000_0008, 32'hCAFE_F00D, 4'hF, 32'h0, 1};
        vecs[6]  = '{0, 32'h8000_0006, 2'd1, 0, 32'h0, 32'hF00D_1234, 2'd0, 1,
                     32'h8000_0004, 32'h0, 4'h0, 32'h0000_F00D, 0};
        vecs[7]  = '{0, 32'h8000_0000, 2'd1, 1, 32'h0, 32'h0000_8001, 2'd0, 1,
                     32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_8001, 0};
        vecs[8]  = '{0, 32'h8000_0001, 2'd0, 0, 32'h0, 32'h0000_AB00, 2'd0, 1,
                     32'h8000_0000, 32'h0, 4'h0, 32'h0000_00AB, 0};
        vecs[9]  = '{1, 32'h8000_0001, 2'd0, 0, 32'h0000_005A, 32'h0, 2'd0, 1,
                     32'h8000_0000, 32'h0000_5A00, 4'b0010, 32'h0, 0};
        vecs[10] = '{1, 32'h8000_0003, 2'd1, 0, 32'h0000_1111, 32'h0, 2'd0, 0,
                     32'h0, 32'h0, 4'h0, 32'h0, 1};
        vecs[11] = '{0, 32'h8000_000C, 2'd2, 1, 32'h0, 32'h8765_4321, 2'd0, 1,
                     32'h8000_000C, 32'h0, 4'h0, 32'h8765_4321, 0};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
        chk("rst_resp", {resp_err, resp_rdata}, 0);
        chk("rst_addr_data", {araddr, awaddr, wdata, wstrb}, 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset while waiting in RDATA with rready high.
        drive_req(1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!arvalid && n < 20) begin @(negedge clk); n++; end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("mid_rready", rready, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
        chk("async_rst_resp", {resp_err, resp_rdata}, 0);
        chk("async_rst_addr", {araddr, awaddr, wdata, wstrb}, 0);
        chk("async_rst_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0]);

        // AW accepted two cycles before W; neither channel may be reissued.
        aw_hs = 0;
        w_hs  = 0;
        drive_req(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'h1122_3344);
        sb.push_back('{32'h0, 1'b0});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!awvalid && n < 20) begin @(negedge clk); n++; end
        awready = 1'b1;
        @(negedge clk);
        chk("split_aw_drop", awvalid, 0);
        chk("split_w_held", wvalid, 1);
        @(negedge clk);
        chk("split_no_bready", bready, 0);
        wready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready  = 1'b0;
        chk("split_w_drop", wvalid, 0);
        chk("split_bready", bready, 1);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        drain();
        chk("split_aw_count", aw_hs, 1);
        chk("split_w_count", w_hs, 1);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
